// File: rtl/operand_fetch.sv
// operand_fetch
//   Fetches the operand bytes that follow an opcode in instruction RAM and
//   assembles them big-endian into one right-aligned operand word. It also
//   reports the PC of the next opcode. The byte count comes from the count ROM
//   latch. A preceding WIDE prefix doubles that count.
//
// Ports
//   clk, reset          clock (rising edge); asynchronous active-low reset
//   start               one-cycle request; accepted only while idle
//   count_in, wide_in   operand byte count and WIDE-prefix flag for the opcode
//   pc_in               address of the opcode byte
//   iram_addr, iram_rd  byte address and one-cycle read strobe to instruction RAM
//   iram_data/_valid    read return; valid is honoured only while waiting
//   operand             assembled operand, zero-extended, held until next start
//   opnd_len, next_pc   bytes fetched and pc_in + 1 + opnd_len
//   busy, done, err     in progress / one-cycle completion / over-length reject
module operand_fetch #(
   parameter int COUNT_W   = 4,
   parameter int ADDR_W    = 16,
   parameter int MAX_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [COUNT_W-1:0]     count_in,
   input  logic                   wide_in,
   input  logic [ADDR_W-1:0]      pc_in,
   output logic [ADDR_W-1:0]      iram_addr,
   output logic                   iram_rd,
   input  logic [7:0]             iram_data,
   input  logic                   iram_valid,
   output logic [8*MAX_BYTES-1:0] operand,
   output logic [COUNT_W-1:0]     opnd_len,
   output logic [ADDR_W-1:0]      next_pc,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int LEN_W = COUNT_W + 1;   // room for the doubled WIDE count
   localparam int OP_W  = 8 * MAX_BYTES;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_FIN
   } state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  idx_inc;
   logic [ADDR_W-1:0] pc;
   logic              err_q;
   logic              len_bad;
   logic              len_zero;

   assign idx_inc  = idx + LEN_W'(1);
   assign len_bad  = (len > LEN_W'(MAX_BYTES));
   assign len_zero = (len == '0);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and read strobe
   always_comb begin
      state_nxt = state;
      iram_rd   = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = (len_bad || len_zero) ? S_FIN : S_ISSUE;
         S_ISSUE: begin
            iram_rd   = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT:  if (iram_valid) state_nxt = (idx_inc == len) ? S_FIN : S_ISSUE;
         S_FIN:   state_nxt = S_IDLE;   // start seen in this cycle is dropped
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: request latch, byte assembly and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= '0;
         len      <= '0;
         idx      <= '0;
         err_q    <= 1'b0;
         operand  <= '0;
         opnd_len <= '0;
         next_pc  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc      <= pc_in;
                  len     <= wide_in ? {count_in, 1'b0} : {1'b0, count_in};
                  idx     <= '0;
                  err_q   <= 1'b0;
                  operand <= '0;
               end
            end
            S_LOAD: begin
               err_q <= len_bad;
               // Nothing to fetch: publish the empty result now.
               if (len_bad || len_zero) begin
                  opnd_len <= '0;
                  next_pc  <= pc + ADDR_W'(1);
               end
            end
            S_WAIT: begin
               if (iram_valid) begin
                  operand <= {operand[OP_W-9:0], iram_data};
                  idx     <= idx_inc;
                  if (idx_inc == len) begin
                     opnd_len <= len[COUNT_W-1:0];
                     next_pc  <= pc + ADDR_W'(1) + ADDR_W'(len);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // The address is held through WAIT because idx only moves when the byte lands.
   assign iram_addr = (state == S_ISSUE || state == S_WAIT)
                      ? pc + ADDR_W'(1) + ADDR_W'(idx) : '0;
   assign busy = (state == S_LOAD) || (state == S_ISSUE) || (state == S_WAIT);
   assign done = (state == S_FIN);
   assign err  = (state == S_FIN) && err_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
   localparam int COUNT_W   = 4;
   localparam int ADDR_W    = 16;
   localparam int MAX_BYTES = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  count_in = '0;
   logic        wide_in = 1'b0;
   logic [15:0] pc_in = '0;
   logic [15:0] iram_addr;
   logic        iram_rd;
   logic [7:0]  iram_data = '0;
   logic        iram_valid = 1'b0;
   logic [31:0] operand;
   logic [3:0]  opnd_len;
   logic [15:0] next_pc;
   logic        busy, done, err;

   int vectors = 0;
   int miscompares = 0;

   operand_fetch #(.COUNT_W(COUNT_W), .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
      .clk(clk), .reset(reset), .start(start), .count_in(count_in),
      .wide_in(wide_in), .pc_in(pc_in), .iram_addr(iram_addr),
      .iram_rd(iram_rd), .iram_data(iram_data), .iram_valid(iram_valid),
      .operand(operand), .opnd_len(opnd_len), .next_pc(next_pc),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Instruction RAM model with programmable read latency (lat cycles after rd).
   logic [7:0]  mem [0:65535];
   int          lat = 1;
   int          pend_cnt = 0;
   logic [7:0]  pend_data = '0;
   int          rd_total = 0;
   logic [15:0] addr_log [0:15];

   always @(posedge clk) begin
      iram_valid <= 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt <= pend_cnt - 1;
         if (pend_cnt == 1) begin
            iram_valid <= 1'b1;
            iram_data  <= pend_data;
         end
      end
      if (iram_rd) begin
         rd_total <= rd_total + 1;
         addr_log[rd_total % 16] <= iram_addr;
         if (lat <= 1) begin
            iram_valid <= 1'b1;
            iram_data  <= mem[iram_addr];
         end else begin
            pend_cnt  <= lat - 1;
            pend_data <= mem[iram_addr];
         end
      end
   end

   typedef struct {
      logic [3:0]  cnt;
      logic        w;
      logic [15:0] pc;
      int          lat;
      logic [31:0] op;
      logic [3:0]  ln;
      logic [15:0] npc;
      logic        e;
      int          cyc;
      int          reads;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: operand is the next len bytes after the opcode read as one
   // big-endian number; over-length requests produce nothing.
   task automatic model(input logic [3:0] c, input logic w, input logic [15:0] p,
                        input int l, output vec_t v);
      int n;
      n = w ? 2 * int'(c) : int'(c);
      v.cnt = c; v.w = w; v.pc = p; v.lat = l;
      v.e   = (n > MAX_BYTES);
      v.op  = '0;
      if (!v.e) begin
         for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = p + 16'(1) + 16'(i);
            v.op = v.op * 256 + 32'(mem[a]);
         end
      end
      v.ln    = v.e ? 4'd0 : 4'(n);
      v.npc   = p + 16'(1) + 16'(v.ln);
      v.reads = v.e ? 0 : n;
      v.cyc   = v.e ? 2 : 2 + n * (1 + l);
   endtask

   task automatic do_fetch(input vec_t v, input string tag);
      int cyc;
      int rd0;
      lat = v.lat;
      rd0 = rd_total;
      @(negedge clk);
      count_in = v.cnt; wide_in = v.w; pc_in = v.pc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      chk({tag, " busy_after_start"}, 64'(busy), 64'(1));
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, " done"}, 64'(done), 64'(1));
      chk({tag, " latency"}, 64'(cyc), 64'(v.cyc));
      chk({tag, " operand"}, 64'(operand), 64'(v.op));
      chk({tag, " opnd_len"}, 64'(opnd_len), 64'(v.ln));
      chk({tag, " next_pc"}, 64'(next_pc), 64'(v.npc));
      chk({tag, " err"}, 64'(err), 64'(v.e));
      chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
      chk({tag, " reads"}, 64'(rd_total - rd0), 64'(v.reads));
      @(negedge clk);
      chk({tag, " done_pulse"}, 64'({done, err}), 64'(0));
      chk({tag, " operand_held"}, 64'(operand), 64'(v.op));
      chk({tag, " next_pc_held"}, 64'(next_pc), 64'(v.npc));
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " busy"}, 64'(busy), 64'(0));
      chk({tag, " done"}, 64'(done), 64'(0));
      chk({tag, " err"}, 64'(err), 64'(0));
      chk({tag, " iram_rd"}, 64'(iram_rd), 64'(0));
      chk({tag, " iram_addr"}, 64'(iram_addr), 64'(0));
      chk({tag, " operand"}, 64'(operand), 64'(0));
      chk({tag, " opnd_len"}, 64'(opnd_len), 64'(0));
      chk({tag, " next_pc"}, 64'(next_pc), 64'(0));
   endtask

   initial begin
      vec_t v;
      int   n;
      int   rd0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0011] = 8'h01; mem[16'h0012] = 8'h2C;
      mem[16'h0101] = 8'h01; mem[16'h0102] = 8'h00;
      mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'hBB;
      mem[16'h0001] = 8'hCC; mem[16'h0002] = 8'hDD;
      mem[16'h0401] = 8'h11; mem[16'h0402] = 8'h22;
      mem[16'h0403] = 8'h33; mem[16'h0404] = 8'h44;

      tbl[0] = '{4'd2, 1'b0, 16'h0010, 1, 32'h0000012C, 4'd2, 16'h0013, 1'b0, 6, 2};
      tbl[1] = '{4'd0, 1'b0, 16'h0040, 1, 32'h00000000, 4'd0, 16'h0041, 1'b0, 2, 0};
      tbl[2] = '{4'd1, 1'b1, 16'h0100, 1, 32'h00000100, 4'd2, 16'h0103, 1'b0, 6, 2};
      tbl[3] = '{4'd4, 1'b0, 16'hFFFE, 1, 32'hAABBCCDD, 4'd4, 16'h0003, 1'b0, 10, 4};
      tbl[4] = '{4'd3, 1'b1, 16'h0200, 1, 32'h00000000, 4'd0, 16'h0201, 1'b1, 2, 0};
      tbl[5] = '{4'd5, 1'b0, 16'h0300, 1, 32'h00000000, 4'd0, 16'h0301, 1'b1, 2, 0};
      tbl[6] = '{4'd2, 1'b1, 16'h0400, 2, 32'h11223344, 4'd4, 16'h0405, 1'b0, 14, 4};

      // Reset state
      repeat (2) @(negedge clk);
      chk_idle_zero("reset");
      reset = 1'b1;

      for (int i = 0; i < 7; i++) begin
         rd0 = rd_total;
         do_fetch(tbl[i], $sformatf("tbl%0d", i));
         if (i == 3) begin
            chk("wrap addr0", 64'(addr_log[(rd0 + 0) % 16]), 64'(16'hFFFF));
            chk("wrap addr1", 64'(addr_log[(rd0 + 1) % 16]), 64'(16'h0000));
            chk("wrap addr2", 64'(addr_log[(rd0 + 2) % 16]), 64'(16'h0001));
            chk("wrap addr3", 64'(addr_log[(rd0 + 3) % 16]), 64'(16'h0002));
         end
      end

      // start presented in the done cycle must be dropped
      lat = 1;
      @(negedge clk);
      count_in = 4'd0; wide_in = 1'b0; pc_in = 16'h0040; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("dropstart done", 64'(done), 64'(1));
      count_in = 4'd2; pc_in = 16'h0500; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("dropstart busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("dropstart busy2", 64'(busy), 64'(0));
      chk("dropstart next_pc", 64'(next_pc), 64'(16'h0041));

      // Reset during the second WAIT with slow RAM; the late return must be ignored
      lat = 3;
      rd0 = rd_total;
      @(negedge clk);
      count_in = 4'd2; wide_in = 1'b0; pc_in = 16'h0010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (rd_total < rd0 + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midreset reached 2nd wait", 64'(rd_total - rd0), 64'(2));
      chk("midreset busy before", 64'(busy), 64'(1));
      reset = 1'b0;
      #1;
      chk_idle_zero("midreset");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("midreset quiet%0d", i), 64'({done, busy, iram_rd}), 64'(0));
         chk($sformatf("midreset operand%0d", i), 64'(operand), 64'(0));
      end
      do_fetch(tbl[0], "after_reset");

      // Randomised requests against the reference model
      for (int i = 0; i < 40; i++) begin
         model(4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 16'($urandom),
               int'($urandom_range(1, 3)), v);
         do_fetch(v, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
